// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forwarding select codes and the hard-wired zero register.
// Latency: n/a (types/constants only). Backpressure: n/a.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_G0 = 5'd0;

  // True when a producer destination really feeds a consumer source.
  // %g0 reads as zero and is never a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_G0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_fwd_unit.sv
// EX-stage operand forwarding select for one ALU operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle regardless of stall/freeze.
// Ports: ex_rs (operand source), mem_rd/mem_regwrite and wb_rd/wb_regwrite
//        (in-flight producers), fwd_sel (00 regfile, 01 EX/MEM, 10 MEM/WB).
module pipeline_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_sel
);

  // The younger producer (MEM) holds the newest value, so it wins over WB.
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_regwrite && reg_match(mem_rd, ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_regwrite && reg_match(wb_rd, ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central enable/clear controller for IF/ID, ID/EX, EX/MEM, MEM/WB plus
// EX operand forwarding selects.
// Latency: all strobes combinational from state and current inputs; the
//   pipeline registers act on them at the next Clk edge.
// Backpressure: a data-memory wait (mem_req & ~mem_ready) freezes the front
//   of the pipe and bubbles MEM/WB until the memory completes.
// Ports: Clk, reset (async active-low); ID/EX/MEM/WB register ids and
//   hazard qualifiers in; pc_en, *_en, *_clr, fwd_a/fwd_b, sticky mem_err
//   and two performance counters out.
// Optional: define PIPELINE_HAZARD_PERF_EN to build the stall/flush
//   counters; otherwise both counter outputs are tied to zero.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_always,
  input  logic             ex_annul,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             ex_mem_clr,
  output logic             mem_wb_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam int unsigned INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic freeze;
  logic lu;
  logic annul;
  logic taken;

  assign freeze = mem_req & ~mem_ready;
  assign lu     = ex_load & (((id_use_rs1 & reg_match(ex_rd, id_rs1))) |
                             ((id_use_rs2 & reg_match(ex_rd, id_rs2))));
  // Untaken annulling branch, or BA,a: the delay slot sitting in ID dies.
  assign annul  = ex_is_branch & ex_annul & (~ex_taken | ex_always);
  assign taken  = ex_is_branch & ex_taken;

  // Next-state and strobe generation.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    pc_en      = 1'b1;
    if_id_en   = 1'b1;
    id_ex_en   = 1'b1;
    ex_mem_en  = 1'b1;
    mem_wb_en  = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_clr  = 1'b0;
    ex_mem_clr = 1'b0;
    mem_wb_clr = 1'b0;

    case (state_q)
      RUN, WAIT: begin
        if (freeze) begin
          // Hold everything up to EX/MEM; bubble MEM/WB so the stalled
          // access is not written back once per wait cycle.
          state_d    = WAIT;
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          id_ex_en   = 1'b0;
          ex_mem_en  = 1'b0;
          mem_wb_clr = 1'b1;
        end else begin
          state_d = RUN;
          if (taken) begin
            if_id_clr = 1'b1;
          end
          if (annul) begin
            // Squashed slot needs no load-use bubble.
            id_ex_clr = 1'b1;
          end else if (lu) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
          end
        end
      end
      default: begin
        // INIT (and any unreachable code): flush the whole pipe.
        state_d    = INIT;
        init_cnt_d = init_cnt_q + 1'b1;
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        id_ex_en   = 1'b0;
        ex_mem_en  = 1'b0;
        mem_wb_en  = 1'b0;
        if_id_clr  = 1'b1;
        id_ex_clr  = 1'b1;
        ex_mem_clr = 1'b1;
        mem_wb_clr = 1'b1;
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
    endcase
  end

  // Memory wait supervision: saturating wait counter and sticky timeout.
  always_comb begin
    wait_cnt_d = '0;
    if (freeze && (state_q != INIT)) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_err_d = mem_err_q | (wait_cnt_d == WAIT_W'(MEM_TIMEOUT));
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  pipeline_fwd_unit u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel      (fwd_a)
  );

  pipeline_fwd_unit u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel      (fwd_b)
  );

`ifdef PIPELINE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_evt;
  logic             flush_evt;

  // INIT-phase clears are the reset flush, not hazards, so they are excluded.
  assign stall_evt = (state_q != INIT) & (freeze | (lu & ~annul));
  assign flush_evt = (state_q != INIT) & (if_id_clr | id_ex_clr);

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_evt);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_evt);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: reset/init flush, load-use,
// branch/annul, memory freeze and timeout, forwarding priority, perf counters.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             Clk;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, ex_load, ex_is_branch, ex_taken;
  logic             ex_always, ex_annul, mem_regwrite, wb_regwrite, mem_req, mem_ready;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
  logic [8:0]       ctrl;

  int n_checks = 0;
  int n_err    = 0;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}
  localparam logic [8:0] C_INIT  = 9'b00000_1111;
  localparam logic [8:0] C_RUN   = 9'b11111_0000;
  localparam logic [8:0] C_LU    = 9'b00111_0100;
  localparam logic [8:0] C_TAKEN = 9'b11111_1000;
  localparam logic [8:0] C_ANNUL = 9'b11111_0100;
  localparam logic [8:0] C_BOTH  = 9'b11111_1100;
  localparam logic [8:0] C_FRZ   = 9'b00001_0001;

`ifdef PIPELINE_HAZARD_PERF_EN
  localparam int EXP_STALL = 7;
  localparam int EXP_FLUSH = 3;
`else
  localparam int EXP_STALL = 0;
  localparam int EXP_FLUSH = 0;
`endif

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr};

  pipeline_hazard_ctrl #(
    .INIT_CYCLES (2),
    .MEM_TIMEOUT (16),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk            (Clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_load        (ex_load),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_always      (ex_always),
    .ex_annul       (ex_annul),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .mem_regwrite   (mem_regwrite),
    .wb_regwrite    (wb_regwrite),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_clr      (if_id_clr),
    .id_ex_clr      (id_ex_clr),
    .ex_mem_clr     (ex_mem_clr),
    .mem_wb_clr     (mem_wb_clr),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .mem_err        (mem_err),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 2 time units after the edge.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_load = 1'b0;
    ex_is_branch = 1'b0; ex_taken = 1'b0; ex_always = 1'b0; ex_annul = 1'b0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_load = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'(C_INIT));
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("rst_stall_cnt", perf_stall_cnt, 32'd0);
    chk("rst_flush_cnt", perf_flush_cnt, 32'd0);

    // Release: two cycles of full flush, then run.
    reset = 1'b1;
    #1;
    chk("init_c1", 32'(ctrl), 32'(C_INIT));
    tick(); #1;
    chk("init_c2", 32'(ctrl), 32'(C_INIT));
    tick(); #1;
    chk("run_default", 32'(ctrl), 32'(C_RUN));
    chk("run_mem_err", 32'(mem_err), 32'd0);

    // Load-use through rs1, rs2, unused source and %g0.
    set_lu(5'd5); #1;
    chk("lu_rs1", 32'(ctrl), 32'(C_LU));
    tick(); ex_load = 1'b0; #1;
    chk("lu_after", 32'(ctrl), 32'(C_RUN));
    set_lu(5'd0); id_rs1 = 5'd0; #1;
    chk("lu_g0", 32'(ctrl), 32'(C_RUN));
    clear_inputs(); ex_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; #1;
    chk("lu_rs2", 32'(ctrl), 32'(C_LU));
    id_use_rs2 = 1'b0; #1;
    chk("lu_not_used", 32'(ctrl), 32'(C_RUN));
    clear_inputs();

    // Branch handling.
    tick();
    ex_is_branch = 1'b1; ex_taken = 1'b1; #1;
    chk("br_taken", 32'(ctrl), 32'(C_TAKEN));
    ex_taken = 1'b0; ex_annul = 1'b1; #1;
    chk("br_untaken_annul", 32'(ctrl), 32'(C_ANNUL));
    ex_always = 1'b1; ex_taken = 1'b1; #1;
    chk("br_ba_annul", 32'(ctrl), 32'(C_BOTH));
    ex_always = 1'b0; #1;
    chk("br_taken_abit", 32'(ctrl), 32'(C_TAKEN));
    ex_taken = 1'b0; set_lu(5'd5); #1;
    chk("annul_beats_lu", 32'(ctrl), 32'(C_ANNUL));
    clear_inputs();

    // Forwarding priority and %g0.
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1;
    ex_rs2 = 5'd3; #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'd1);
    chk("fwd_b_none", 32'(fwd_b), 32'd0);
    mem_regwrite = 1'b0; #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'd2);
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1; #1;
    chk("fwd_a_g0", 32'(fwd_a), 32'd0);
    wb_rd = 5'd3; #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'd2);
    clear_inputs();

    // Memory freeze for 20 cycles; a load-use hazard is present but overridden.
    tick();
    mem_req = 1'b1; mem_ready = 1'b0; set_lu(5'd5); #1;
    chk("frz_ctrl_0", 32'(ctrl), 32'(C_FRZ));
    chk("frz_err_0", 32'(mem_err), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick(); #1;
      chk("frz_ctrl", 32'(ctrl), 32'(C_FRZ));
      chk("frz_err", 32'(mem_err), (k >= 16) ? 32'd1 : 32'd0);
    end
    clear_inputs(); mem_req = 1'b1; mem_ready = 1'b1; #1;
    chk("frz_release", 32'(ctrl), 32'(C_RUN));
    tick(); mem_req = 1'b0; #1;
    chk("run_after_wait", 32'(ctrl), 32'(C_RUN));
    chk("mem_err_sticky", 32'(mem_err), 32'd1);

    // Mid-operation reset, then count 3 load-use stalls and 4 freeze cycles.
    tick();
    reset = 1'b0; #1;
    chk("rst2_ctrl", 32'(ctrl), 32'(C_INIT));
    chk("rst2_mem_err", 32'(mem_err), 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick(); #1;
    chk("rst2_run", 32'(ctrl), 32'(C_RUN));
    chk("rst2_stall_cnt", perf_stall_cnt, 32'd0);
    set_lu(5'd5);
    repeat (3) tick();
    clear_inputs(); mem_req = 1'b1;
    repeat (4) tick();
    clear_inputs(); #1;
    chk("perf_stall", perf_stall_cnt, 32'(EXP_STALL));
    chk("perf_flush", perf_flush_cnt, 32'(EXP_FLUSH));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
